cpu_run_ctrl: RTL and testbench

Parametrised run-control block for the pipelined MIPS bench. It replaces the free-running clock and fixed-delay finish with a cycle-accurate controller. It gates the CPU through a clock-enable, runs, pauses and single-steps under a pulse interface, and counts executed cycles against a configurable timeout. It also derives NCH divided enables for slow peripherals. It sits between the bench clock source and `cpu`, and all logic is in the `clk` domain.

---
 rtl/cpu_run_ctrl.sv | 106 ++++++++++
 tb/tb_cpu_run_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - cycle-accurate run/pause/step controller with timeout and divided enables.
// Optional RUN_CTRL_FINISH_EN adds a simulation-only report and $finish on entering DONE.
module cpu_run_ctrl #(
  parameter int NCH        = 2,
  parameter int DIVW       = 8,
  parameter int CNTW       = 32,
  parameter int MAX_CYCLES = 35
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  step,
  input  logic [NCH*DIVW-1:0]   div,
  output logic                  cpu_en,
  output logic [NCH-1:0]        ch_en,
  output logic [CNTW-1:0]       cycles,
  output logic [1:0]            state,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(MAX_CYCLES - 1);

  state_t          state_q, state_d;
  logic            step_q, step_d;
  logic [CNTW-1:0] cycles_q;
  logic            timeout_hit;

  assign cpu_en      = (state_q == RUN) | ((state_q == PAUSE) & step_q);
  assign timeout_hit = (MAX_CYCLES != 0) && cpu_en && (cycles_q == LAST);
  assign cycles      = cycles_q;
  assign state       = state_q;
  assign done        = (state_q == DONE);

  // Timeout outranks stop/start so a step can also end the run.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (timeout_hit) state_d = DONE;
        else if (stop)   state_d = PAUSE;
      end
      PAUSE: begin
        if (timeout_hit)  state_d = DONE;
        else if (start)   state_d = RUN;
        else if (step)    step_d  = 1'b1;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (cpu_en) cycles_q <= cycles_q + CNTW'(1);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIVW-1:0] cnt_q;
    logic [DIVW-1:0] div_k;
    logic            hit;

    assign div_k    = div[k*DIVW +: DIVW];
    assign hit      = (cnt_q >= div_k);
    assign ch_en[k] = cpu_en & hit;

    always_ff @(posedge clk) begin
      if (reset)       cnt_q <= '0;
      else if (cpu_en) cnt_q <= hit ? '0 : cnt_q + DIVW'(1);
    end
  end

`ifdef RUN_CTRL_FINISH_EN
  always_ff @(posedge clk) begin
    if (!reset && (state_q != DONE) && (state_d == DONE)) begin
      $display("run_ctrl: done at %0d cycles", cycles_q + CNTW'(1));
      $finish;
    end
  end
`else
  // done is the only termination indication; the bench decides when to stop.
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - table-driven scoreboard bench for cpu_run_ctrl.
module tb_cpu_run_ctrl;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic        w_start = 1'b0, w_stop = 1'b0, w_step = 1'b0;
  logic [15:0] div = {8'd0, 8'd3};

  logic        cpu_en, done, cpu_en_w, done_w;
  logic [1:0]  ch_en, ch_en_w, state, state_w;
  logic [31:0] cycles;
  logic [3:0]  cycles_w;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.NCH(2), .DIVW(8), .CNTW(32), .MAX_CYCLES(35)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step), .div(div),
    .cpu_en(cpu_en), .ch_en(ch_en), .cycles(cycles), .state(state), .done(done)
  );

  cpu_run_ctrl #(.NCH(2), .DIVW(8), .CNTW(4), .MAX_CYCLES(0)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .stop(w_stop), .step(w_step), .div(div),
    .cpu_en(cpu_en_w), .ch_en(ch_en_w), .cycles(cycles_w), .state(state_w), .done(done_w)
  );

  typedef struct {
    logic        r, s, p, t;
    logic [1:0]  st;
    logic        en;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  function automatic void add(logic r, logic s, logic p, logic t,
                              logic [1:0] st, logic en, int cyc);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.t = t; v.st = st; v.en = en; v.cyc = 32'(cyc);
    tbl.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    logic [1:0] exp_ch;

    // Run to timeout; stop/step ignored in IDLE; inputs ignored in DONE.
    add(1,0,0,0, S_IDLE,0,0);
    add(0,0,1,1, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    for (int i = 1; i < 35; i++) add(0,0,0,0, S_RUN,1,i);
    add(0,0,0,0, S_DONE,0,35);
    add(0,1,0,1, S_DONE,0,35);
    add(0,0,1,0, S_DONE,0,35);

    // Pause at 10 (stop beats start), resume, timeout beats stop.
    add(1,0,0,0, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    for (int i = 1; i < 10; i++) add(0,0,0,0, S_RUN,1,i);
    add(0,1,1,0, S_PAUSE,0,10);
    for (int i = 0; i < 5; i++) add(0,0,0,0, S_PAUSE,0,10);
    add(0,1,0,0, S_RUN,1,10);
    for (int i = 11; i < 35; i++) add(0,0,0,0, S_RUN,1,i);
    add(0,0,1,0, S_DONE,0,35);
    add(0,0,0,0, S_DONE,0,35);

    // Single steps, start+step resume, held step.
    add(1,0,0,0, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    for (int i = 1; i < 4; i++) add(0,0,0,0, S_RUN,1,i);
    add(0,0,1,0, S_PAUSE,0,4);
    add(0,0,0,1, S_PAUSE,1,4);
    add(0,0,0,0, S_PAUSE,0,5);
    add(0,0,0,1, S_PAUSE,1,5);
    add(0,0,0,0, S_PAUSE,0,6);
    add(0,0,0,1, S_PAUSE,1,6);
    add(0,0,0,0, S_PAUSE,0,7);
    add(0,1,0,1, S_RUN,1,7);
    add(0,0,0,0, S_RUN,1,8);
    add(0,0,1,0, S_PAUSE,0,9);
    add(0,0,0,1, S_PAUSE,1,9);
    add(0,0,0,1, S_PAUSE,1,10);
    add(0,0,0,1, S_PAUSE,1,11);
    add(0,0,0,0, S_PAUSE,0,12);

    // Reset mid-run together with start, then restart.
    add(1,0,0,0, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    for (int i = 1; i <= 20; i++) add(0,0,0,0, S_RUN,1,i);
    add(1,1,0,0, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    add(0,0,0,0, S_RUN,1,1);

    // Timeout reached through a paused step.
    add(1,0,0,0, S_IDLE,0,0);
    add(0,1,0,0, S_RUN,1,0);
    for (int i = 1; i < 34; i++) add(0,0,0,0, S_RUN,1,i);
    add(0,0,1,0, S_PAUSE,0,34);
    add(0,0,0,1, S_PAUSE,1,34);
    add(0,0,0,0, S_DONE,0,35);
    add(0,1,0,0, S_DONE,0,35);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].r; start = tbl[i].s; stop = tbl[i].p; step = tbl[i].t;
      exp_q.push_back(tbl[i]);
      tick();
      reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0;
      e = exp_q.pop_front();
      // div={0,3}: ch1 mirrors cpu_en, ch0 fires on every 4th executed cycle.
      exp_ch = {e.en, e.en & (e.cyc[1:0] == 2'b11)};
      chk($sformatf("v%0d_state", i),  64'(state),  64'(e.st));
      chk($sformatf("v%0d_cpu_en", i), 64'(cpu_en), 64'(e.en));
      chk($sformatf("v%0d_cycles", i), 64'(cycles), 64'(e.cyc));
      chk($sformatf("v%0d_ch_en", i),  64'(ch_en),  64'(exp_ch));
      chk($sformatf("v%0d_done", i),   64'(done),   64'(e.st == S_DONE));
    end

    // Lowering div below the live count fires at once, then restarts from 0.
    div[7:0] = 8'd10;
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    chk("lower_pre_cycles", 64'(cycles), 64'd6);
    chk("lower_pre_ch0", 64'(ch_en[0]), 64'd0);
    div[7:0] = 8'd2;
    #1;
    chk("lower_fire", 64'(ch_en[0]), 64'd1);
    tick(); chk("lower_after0", 64'(ch_en[0]), 64'd0);
    tick(); chk("lower_after1", 64'(ch_en[0]), 64'd0);
    tick(); chk("lower_after2", 64'(ch_en[0]), 64'd1);
    tick(); chk("lower_after3", 64'(ch_en[0]), 64'd0);

    // No-timeout instance: counter wraps, done never rises.
    div[7:0] = 8'd3;
    reset = 1'b1; tick(); reset = 1'b0;
    w_start = 1'b1; tick(); w_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap%0d_cycles", i), 64'(cycles_w), 64'(i % 16));
      chk($sformatf("wrap%0d_done", i), 64'(done_w), 64'd0);
      chk($sformatf("wrap%0d_ch_en", i), 64'(ch_en_w), 64'({1'b1, (i % 4) == 3}));
      tick();
    end
    chk("wrap_state", 64'(state_w), 64'(S_RUN));
    chk("wrap_idle_main", 64'(state), 64'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
